// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port RAM, synchronous write, registered read
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the output register is reset; the array keeps its contents
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with wrap-bit pointers and 1-cycle read latency
module async_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in_vld,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  fifo_full,
  input  logic                  read_req,
  output logic                  data_out_vld,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty
);
  localparam int FIFO_DEPTH_WIDTH = $clog2(FIFO_DEPTH);
  logic [FIFO_DEPTH_WIDTH:0] wr_ptr, rd_ptr;
  logic we, re;
  assign fifo_empty = wr_ptr == rd_ptr;
  assign fifo_full  = wr_ptr[FIFO_DEPTH_WIDTH-1:0] == rd_ptr[FIFO_DEPTH_WIDTH-1:0] &&
                      wr_ptr[FIFO_DEPTH_WIDTH] != rd_ptr[FIFO_DEPTH_WIDTH];
  assign we = data_in_vld && !fifo_full;
  assign re = read_req && !fifo_empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_out_vld <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      data_out_vld <= re;
    end
  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_WIDTH(FIFO_DEPTH_WIDTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(wr_ptr[FIFO_DEPTH_WIDTH-1:0]),
    .wdata(data_in),
    .re   (re),
    .raddr(rd_ptr[FIFO_DEPTH_WIDTH-1:0]),
    .rdata(data_out)
  );
endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed scoreboard bench for async_fifo (32 x 8)
module tb_async_fifo;
  logic clk = 0, rst_n = 1, data_in_vld = 0, read_req = 0;
  logic [31:0] data_in = 0;
  logic fifo_full, data_out_vld, fifo_empty;
  logic [31:0] data_out;
  logic [31:0] mq[$], sb[$];
  logic [31:0] last = 0;
  int checks = 0, passes = 0, fails = 0;

  async_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_vld(data_in_vld), .data_in(data_in),
    .fifo_full(fifo_full), .read_req(read_req), .data_out_vld(data_out_vld),
    .data_out(data_out), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // model decides acceptance from pre-edge occupancy, queues expected read data
  task automatic cyc(input logic w, input logic [31:0] d, input logic r);
    logic wacc, racc;
    logic [31:0] e;
    data_in_vld = w; data_in = d; read_req = r;
    wacc = w && mq.size() < 8;
    racc = r && mq.size() > 0;
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    @(posedge clk); #1;
    chk("vld", data_out_vld, racc);
    if (racc) begin
      e = sb.pop_front();
      last = e;
      chk("data", data_out, e);
    end else chk("hold", data_out, last);
    chk("empty", fifo_empty, mq.size() == 0);
    chk("full", fifo_full, mq.size() == 8);
  endtask

  task automatic async_reset();
    rst_n = 0;
    #1;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_vld", data_out_vld, 0);
    chk("rst_data", data_out, 0);
    mq.delete(); sb.delete(); last = 0;
    data_in_vld = 0; read_req = 0;
    @(posedge clk); #3;
    rst_n = 1;
  endtask

  initial begin
    #1 async_reset();
    // fill, then a dropped 9th write
    for (int i = 0; i < 9; i++) cyc(1, i, 0);
    // drain plus one read on empty
    for (int i = 0; i < 9; i++) cyc(0, 0, 1);
    chk("drain_hold7", data_out, 7);
    // stream with reads starting 5 cycles late
    for (int i = 0; i < 110; i++) cyc(i < 100, 1000 + i, i >= 5);
    // full with simultaneous write and read
    for (int i = 0; i < 8; i++) cyc(1, 200 + i, 0);
    cyc(1, 99, 1);
    chk("full_wr_rd_notfull", fifo_full, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    // empty with simultaneous write and read
    cyc(1, 55, 1);
    chk("empty_wr_rd_novld", data_out_vld, 0);
    cyc(0, 0, 1);
    // reset in the middle of traffic
    for (int i = 0; i < 5; i++) cyc(1, 300 + i, 0);
    async_reset();
    cyc(0, 0, 1);
    cyc(1, 42, 0);
    cyc(0, 0, 1);
    chk("readback42", data_out, 42);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
